// File: rtl/fp_sqrt_sched_pkg.sv
// Shared types for the FP square-root scheduler: FSM states, cluster-wide FP flag
// layout, rounding-mode encodings and the rounding-increment decision.
package fp_sqrt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // Square roots of non-NaN operands are never negative, so RDN/RTZ truncate and RUP rounds up.
  function automatic logic round_inc(input logic [2:0] rm, input logic lsb,
                                     input logic grd, input logic stk);
    case (rm)
      RM_RNE:  return grd & (stk | lsb);
      RM_RUP:  return grd | stk;
      RM_RMM:  return grd;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/FP_Sqrt.sv
// Shared FP square-root datapath, purely combinational; SP operands live in [31:0]
// and SP results are returned zero-extended.
module FP_Sqrt
  import fp_sqrt_sched_pkg::*;
(
  input  logic [63:0] i_a,
  input  logic        i_is_dp,
  input  logic [2:0]  i_rm,
  output logic [63:0] o_result,
  output fp_flags_t   o_flags
);

  logic [63:0] w_dp_res;
  logic [31:0] w_sp_res;
  fp_flags_t   w_dp_flg, w_sp_flg;

  sqrt_core #(.EW(11), .MW(52)) u_dp (
    .i_a(i_a), .i_rm(i_rm), .o_res(w_dp_res), .o_flags(w_dp_flg)
  );

  sqrt_core #(.EW(8), .MW(23)) u_sp (
    .i_a(i_a[31:0]), .i_rm(i_rm), .o_res(w_sp_res), .o_flags(w_sp_flg)
  );

  assign o_result = i_is_dp ? w_dp_res : {32'h0, w_sp_res};
  assign o_flags  = i_is_dp ? w_dp_flg : w_sp_flg;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after i_ptr, wrapping N-1 -> 0.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_en,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_en && i_req[wrap_add(i_ptr, k)]) begin
        o_grant                     = '0;
        o_grant[wrap_add(i_ptr, k)] = 1'b1;
        o_idx                       = wrap_add(i_ptr, k);
      end
    end
  end

endmodule

// File: rtl/sqrt_core.sv
// Combinational IEEE-754 square root for one format (EW exponent bits, MW fraction bits).
// Digit-by-digit restoring root; the final remainder supplies the sticky bit.
module sqrt_core
  import fp_sqrt_sched_pkg::*;
#(
  parameter int EW = 11,
  parameter int MW = 52
) (
  input  logic [EW+MW:0] i_a,
  input  logic [2:0]     i_rm,
  output logic [EW+MW:0] o_res,
  output fp_flags_t      o_flags
);

  localparam int QW     = MW + 2;
  localparam int RW     = 2 * QW;
  localparam int BIAS_I = 2 ** (EW - 1) - 1;

  logic          w_sign;
  logic [EW-1:0] w_exp;
  logic [MW-1:0] w_frac;
  assign {w_sign, w_exp, w_frac} = i_a;

  logic          w_exp_max, w_exp_zero, w_frac_nz;
  logic [EW:0]   w_e;
  logic [MW:0]   w_m;
  logic [QW-1:0] w_madj, w_q;
  logic [RW-1:0] w_rad;
  logic [QW+1:0] w_rem, w_trial;
  logic [MW:0]   w_mr;
  logic          w_grd, w_stk, w_inc;
  logic [EW-1:0] w_rexp;

  assign w_exp_max  = &w_exp;
  assign w_exp_zero = ~|w_exp;
  assign w_frac_nz  = |w_frac;

  always_comb begin
    // Unbiased exponent kept modulo 2^(EW+1); halving uses bits [EW:1] which stays exact.
    w_m = {~w_exp_zero, w_frac};
    w_e = w_exp_zero ? (EW+1)'(1 - BIAS_I) : ({1'b0, w_exp} - (EW+1)'(BIAS_I));
    for (int k = 0; k < MW; k++) begin
      if (!w_m[MW]) begin
        w_m = w_m << 1;
        w_e = w_e - (EW+1)'(1);
      end
    end
    w_madj = w_e[0] ? {w_m, 1'b0} : {1'b0, w_m};
    w_rad  = {w_madj, {QW{1'b0}}};

    w_rem   = '0;
    w_q     = '0;
    w_trial = '0;
    for (int i = QW - 1; i >= 0; i--) begin
      w_rem   = {w_rem[QW-1:0], w_rad[2*i+1 -: 2]};
      w_trial = {w_q, 2'b01};
      if (w_rem >= w_trial) begin
        w_rem = w_rem - w_trial;
        w_q   = {w_q[QW-2:0], 1'b1};
      end else begin
        w_q   = {w_q[QW-2:0], 1'b0};
      end
    end

    // w_q = 1.fraction plus one guard bit; a carry out of the fraction bumps the exponent.
    w_grd  = w_q[0];
    w_stk  = |w_rem;
    w_inc  = round_inc(i_rm, w_q[1], w_grd, w_stk);
    w_mr   = {1'b0, w_q[MW:1]} + (MW+1)'(w_inc);
    w_rexp = w_e[EW:1] + EW'(BIAS_I) + EW'(w_mr[MW]);

    o_flags = '0;
    if (w_exp_max && w_frac_nz) begin
      o_res           = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      o_flags.invalid = ~w_frac[MW-1];
    end else if (w_exp_zero && !w_frac_nz) begin
      o_res = i_a;
    end else if (w_sign) begin
      o_res           = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      o_flags.invalid = 1'b1;
    end else if (w_exp_max) begin
      o_res = i_a;
    end else begin
      o_res           = {1'b0, w_rexp, w_mr[MW-1:0]};
      o_flags.inexact = w_grd | w_stk;
    end
  end

endmodule

// File: rtl/fp_sqrt_sched.sv
// Round-robin scheduler sharing one multicycle FP_Sqrt among NUM_REQ requesters,
// one op in flight: grant, hold operands MC_CYCLES cycles, register and return result.
module fp_sqrt_sched
  import fp_sqrt_sched_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int MC_CYCLES = 3,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0][63:0] req_operand,
  input  logic [NUM_REQ-1:0]      req_is_dp,
  input  logic [NUM_REQ-1:0][2:0] req_rm,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [63:0]             resp_result,
  output logic [3:0]              resp_flags,
  output logic                    busy
);

  localparam int CNT_W = $clog2(MC_CYCLES + 1);

  sched_state_t r_state, w_next;

  logic [63:0]      r_op;
  logic             r_is_dp;
  logic [2:0]       r_rm;
  logic [ID_W-1:0]  r_id, r_ptr, r_resp_id;
  logic [CNT_W-1:0] r_cnt;
  logic             r_resp_valid;
  logic [63:0]      r_resp_result;
  fp_flags_t        r_resp_flags;

  logic               w_arb_en, w_accept;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_gidx;
  logic [63:0]        w_sq_res;
  fp_flags_t          w_sq_flags;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .i_req(req_valid), .i_ptr(r_ptr), .i_en(w_arb_en),
    .o_grant(w_grant), .o_idx(w_gidx)
  );

  // Inputs come only from r_op/r_is_dp/r_rm, so these paths carry a MC_CYCLES multicycle constraint.
  FP_Sqrt u_sqrt (
    .i_a(r_op), .i_is_dp(r_is_dp), .i_rm(r_rm),
    .o_result(w_sq_res), .o_flags(w_sq_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = EXEC;
      EXEC:    if (r_cnt == '0) w_next = RESP;
      RESP:    if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_arb_en  = (r_state == IDLE);
    w_accept  = |w_grant;
    req_ready = w_grant;
    busy      = (r_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op          <= '0;
      r_is_dp       <= 1'b0;
      r_rm          <= '0;
      r_id          <= '0;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_id     <= '0;
      r_resp_result <= '0;
      r_resp_flags  <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= req_operand[w_gidx];
        r_is_dp <= req_is_dp[w_gidx];
        r_rm    <= req_rm[w_gidx];
        r_id    <= w_gidx;
        r_cnt   <= CNT_W'(MC_CYCLES - 1);
        r_ptr   <= (w_gidx == ID_W'(NUM_REQ - 1)) ? '0 : w_gidx + ID_W'(1);
      end
      if (r_state == EXEC) begin
        if (r_cnt == '0) begin
          r_resp_valid  <= 1'b1;
          r_resp_id     <= r_id;
          r_resp_result <= w_sq_res;
          r_resp_flags  <= w_sq_flags;
        end else begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
      if (r_state == RESP && resp_ready) r_resp_valid <= 1'b0;
    end
  end

  assign resp_valid  = r_resp_valid;
  assign resp_id     = r_resp_id;
  assign resp_result = r_resp_result;
  assign resp_flags  = r_resp_flags;

endmodule
